// File: rtl/cpu_control_sequencer_pkg.sv
// Shared constants for the accumulator-CPU control sequencer: widths, FSM encodings,
// opcodes and datapath mux selects.
package cpu_ctrl_pkg;

    localparam int unsigned OPW     = 8;
    localparam int unsigned TMO_MAX = 15;
    localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM_RD = 3'd3;
    localparam logic [2:0] ST_MEM_WR = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    localparam logic [OPW-1:0] OP_NOP  = 8'h00;
    localparam logic [OPW-1:0] OP_LDI  = 8'h01;
    localparam logic [OPW-1:0] OP_LDA  = 8'h02;
    localparam logic [OPW-1:0] OP_STA  = 8'h03;
    localparam logic [OPW-1:0] OP_ADD  = 8'h04;
    localparam logic [OPW-1:0] OP_SUB  = 8'h05;
    localparam logic [OPW-1:0] OP_AND  = 8'h06;
    localparam logic [OPW-1:0] OP_OR   = 8'h07;
    localparam logic [OPW-1:0] OP_JMP  = 8'h08;
    localparam logic [OPW-1:0] OP_JZ   = 8'h09;
    localparam logic [OPW-1:0] OP_JC   = 8'h0A;
    localparam logic [OPW-1:0] OP_JMPM = 8'h0B;
    localparam logic [OPW-1:0] OP_HLT  = 8'hFF;

    localparam logic [1:0] SELACC_IMM = 2'b00;
    localparam logic [1:0] SELACC_MEM = 2'b01;
    localparam logic [1:0] SELACC_ALU = 2'b10;
    localparam logic       SELPC_IMM  = 1'b0;
    localparam logic       SELPC_MEM  = 1'b1;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between the sequencer (master) and the CPU datapath/memory (slave).
interface cpu_control_sequencer_if;

    logic                         run;
    logic [cpu_ctrl_pkg::OPW-1:0] opcode;
    logic                         z;
    logic                         c;
    logic                         mem_ready;
    logic                         loadIR;
    logic                         incPC;
    logic                         loadPC;
    logic                         selPC;
    logic                         loadacc;
    logic [1:0]                   selacc;
    logic                         rd_en;
    logic                         wr_en;
    logic [cpu_ctrl_pkg::OPW-1:0] alu_op;
    logic                         halted;
    logic                         fault;

    modport master (
        input  run, opcode, z, c, mem_ready,
        output loadIR, incPC, loadPC, selPC, loadacc, selacc, rd_en, wr_en, alu_op, halted, fault
    );

    modport slave (
        output run, opcode, z, c, mem_ready,
        input  loadIR, incPC, loadPC, selPC, loadacc, selacc, rd_en, wr_en, alu_op, halted, fault
    );

endinterface

// File: rtl/cpu_control_sequencer_decode.sv
// Combinational opcode classifier shared by the DECODE and EXEC states.
module cpu_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW-1:0] opcode_i,
    output logic           is_mem_rd_o,
    output logic           is_mem_wr_o,
    output logic           is_alu_o,
    output logic           is_jump_o,
    output logic           is_halt_o,
    output logic           illegal_o
);

    always_comb begin
        is_mem_rd_o = 1'b0;
        is_mem_wr_o = 1'b0;
        is_alu_o    = 1'b0;
        is_jump_o   = 1'b0;
        is_halt_o   = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OP_NOP, OP_LDI: ;
            OP_LDA:                        is_mem_rd_o = 1'b1;
            OP_STA:                        is_mem_wr_o = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                is_alu_o    = 1'b1;
                is_mem_rd_o = 1'b1;
            end
            OP_JMP, OP_JZ, OP_JC:          is_jump_o = 1'b1;
            OP_JMPM: begin
                is_jump_o   = 1'b1;
                is_mem_rd_o = 1'b1;
            end
            OP_HLT:                        is_halt_o = 1'b1;
            default:                       illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU, with memory-ready
// timeout, run/pause, HALT and a sticky fault flag.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rstn,
    cpu_control_sequencer_if.master        ctl
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    logic [2:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fault_q, fault_d;

    logic is_mem_rd, is_mem_wr, is_alu, is_jump, is_halt, illegal;

    logic           loadir_c, incpc_c, loadpc_c, selpc_c, loadacc_c, rd_c, wr_c, halted_c, fault_c;
    logic [1:0]     selacc_c;
    logic [OPW-1:0] aluop_c;

    cpu_opcode_decode u_decode (
        .opcode_i    (ctl.opcode),
        .is_mem_rd_o (is_mem_rd),
        .is_mem_wr_o (is_mem_wr),
        .is_alu_o    (is_alu),
        .is_jump_o   (is_jump),
        .is_halt_o   (is_halt),
        .illegal_o   (illegal)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FETCH;
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end

    // Next state and strobes; the wait counter defaults to clear so it resets on leaving MEM_*.
    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        fault_d   = fault_q;
        loadir_c  = 1'b0;
        incpc_c   = 1'b0;
        loadpc_c  = 1'b0;
        selpc_c   = SELPC_IMM;
        loadacc_c = 1'b0;
        selacc_c  = SELACC_IMM;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        aluop_c   = '0;
        halted_c  = 1'b0;
        fault_c   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (ctl.run) begin
                    loadir_c = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_halt)        state_d = ST_HALT;
                else if (is_mem_rd) state_d = ST_MEM_RD;
                else if (is_mem_wr) state_d = ST_MEM_WR;
                else                state_d = ST_EXEC;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                rd_c = (state_q == ST_MEM_RD);
                wr_c = (state_q == ST_MEM_WR);
                if (ctl.mem_ready) begin
                    incpc_c = wr_c;
                    state_d = wr_c ? ST_FETCH : ST_EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (illegal) begin
                    fault_c = 1'b1;
                    fault_d = 1'b1;
                    incpc_c = 1'b1;
                end else if (is_alu) begin
                    aluop_c   = ctl.opcode;
                    loadacc_c = 1'b1;
                    selacc_c  = SELACC_ALU;
                    incpc_c   = 1'b1;
                end else if (is_jump) begin
                    case (ctl.opcode)
                        OP_JZ:   begin loadpc_c = ctl.z; incpc_c = ~ctl.z; end
                        OP_JC:   begin loadpc_c = ctl.c; incpc_c = ~ctl.c; end
                        OP_JMPM: begin loadpc_c = 1'b1;  selpc_c = SELPC_MEM; end
                        default: loadpc_c = 1'b1;
                    endcase
                end else begin
                    incpc_c = 1'b1;
                    case (ctl.opcode)
                        OP_LDI:  loadacc_c = 1'b1;
                        OP_LDA:  begin loadacc_c = 1'b1; selacc_c = SELACC_MEM; end
                        default: ;
                    endcase
                end
            end
            ST_HALT:  halted_c = 1'b1;
            ST_FAULT: ;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Reset silences every output at once, even in FETCH where run would otherwise raise loadIR.
    assign ctl.loadIR  = rstn & loadir_c;
    assign ctl.incPC   = rstn & incpc_c;
    assign ctl.loadPC  = rstn & loadpc_c;
    assign ctl.selPC   = rstn & selpc_c;
    assign ctl.loadacc = rstn & loadacc_c;
    assign ctl.selacc  = rstn ? selacc_c : 2'b00;
    assign ctl.rd_en   = rstn & rd_c;
    assign ctl.wr_en   = rstn & wr_c;
    assign ctl.alu_op  = rstn ? aluop_c : '0;
    assign ctl.halted  = rstn & halted_c;
    assign ctl.fault   = rstn & (fault_q | fault_c);

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: per-cycle vector table plus hand sequences
// for reset, timeout, halt and illegal-opcode corners.
module tb_cpu_control_sequencer;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic       loadIR;
        logic       incPC;
        logic       loadPC;
        logic       selPC;
        logic       loadacc;
        logic [1:0] selacc;
        logic       rd_en;
        logic       wr_en;
        logic [7:0] alu_op;
        logic       halted;
        logic       fault;
    } out_t;

    typedef struct packed {
        logic       run;
        logic [7:0] op;
        logic       z;
        logic       c;
        logic       rdy;
        out_t       exp;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cpu_control_sequencer_if bus ();

    cpu_control_sequencer dut (
        .clk  (clk),
        .rstn (rstn),
        .ctl  (bus)
    );

    int   total = 0;
    int   bad   = 0;
    out_t sb[$];
    vec_t tbl[$];

    function automatic out_t o(input logic ir, inc, ldpc, spc, ldacc, input logic [1:0] sacc,
                               input logic rd, wr, input logic [7:0] alu, input logic hlt, flt);
        out_t r;
        r = '{ir, inc, ldpc, spc, ldacc, sacc, rd, wr, alu, hlt, flt};
        return r;
    endfunction

    function automatic vec_t v(input logic run, input logic [7:0] op, input logic z, c, rdy,
                               input out_t e);
        vec_t r;
        r = '{run, op, z, c, rdy, e};
        return r;
    endfunction

    function automatic out_t sample_out();
        out_t r;
        r = '{bus.loadIR, bus.incPC, bus.loadPC, bus.selPC, bus.loadacc, bus.selacc,
              bus.rd_en, bus.wr_en, bus.alu_op, bus.halted, bus.fault};
        return r;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = sample_out();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic run, input logic [7:0] op, input logic z, c, rdy, input out_t e);
        bus.run       = run;
        bus.opcode    = op;
        bus.z         = z;
        bus.c         = c;
        bus.mem_ready = rdy;
        sb.push_back(e);
    endtask

    task automatic apply(input string name);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s got=no-expectation expected=queued-entry", name);
        end else begin
            check(name, sb.pop_front());
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic run, input logic [7:0] op,
                        input logic z, c, rdy, input out_t e);
        drive(run, op, z, c, rdy, e);
        apply(name);
        adv();
    endtask

    task automatic do_reset(input string name);
        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;
        rstn          = 1'b0;
        #1;
        check(name, '0);
        adv();
        rstn = 1'b1;
    endtask

    out_t N, IR, INC, LDPC0, LDPC1, RD, WR, WRINC, LDI_E, LDA_E, HLT_E, FLT, FLTINC, IRF, INCF;

    initial begin
        N      = '0;
        IR     = o(1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0);
        INC    = o(0, 1, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0);
        LDPC0  = o(0, 0, 1, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0);
        LDPC1  = o(0, 0, 1, 1, 0, 2'b00, 0, 0, 8'h00, 0, 0);
        RD     = o(0, 0, 0, 0, 0, 2'b00, 1, 0, 8'h00, 0, 0);
        WR     = o(0, 0, 0, 0, 0, 2'b00, 0, 1, 8'h00, 0, 0);
        WRINC  = o(0, 1, 0, 0, 0, 2'b00, 0, 1, 8'h00, 0, 0);
        LDI_E  = o(0, 1, 0, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0);
        LDA_E  = o(0, 1, 0, 0, 1, 2'b01, 0, 0, 8'h00, 0, 0);
        HLT_E  = o(0, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 1, 0);
        FLT    = o(0, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 1);
        FLTINC = o(0, 1, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 1);
        IRF    = o(1, 0, 0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 1);
        INCF   = FLTINC;

        bus.run = 1'b1; bus.opcode = 8'h00; bus.z = 1'b0; bus.c = 1'b0; bus.mem_ready = 1'b0;

        // LDI: loadIR, idle decode, load immediate
        tbl.push_back(v(1, 8'h01, 0, 0, 0, IR));
        tbl.push_back(v(1, 8'h01, 0, 0, 0, N));
        tbl.push_back(v(1, 8'h01, 0, 0, 0, LDI_E));
        // LDA with immediate ready
        tbl.push_back(v(1, 8'h02, 0, 0, 1, IR));
        tbl.push_back(v(1, 8'h02, 0, 0, 1, N));
        tbl.push_back(v(1, 8'h02, 0, 0, 1, RD));
        tbl.push_back(v(1, 8'h02, 0, 0, 0, LDA_E));
        // ADD, ready ignored in DECODE, two wait cycles
        tbl.push_back(v(1, 8'h04, 0, 0, 0, IR));
        tbl.push_back(v(1, 8'h04, 0, 0, 1, N));
        tbl.push_back(v(1, 8'h04, 0, 0, 0, RD));
        tbl.push_back(v(1, 8'h04, 0, 0, 0, RD));
        tbl.push_back(v(1, 8'h04, 0, 0, 1, RD));
        tbl.push_back(v(1, 8'h04, 0, 0, 0, o(0, 1, 0, 0, 1, 2'b10, 0, 0, 8'h04, 0, 0)));
        // OR
        tbl.push_back(v(1, 8'h07, 0, 0, 1, IR));
        tbl.push_back(v(1, 8'h07, 0, 0, 1, N));
        tbl.push_back(v(1, 8'h07, 0, 0, 1, RD));
        tbl.push_back(v(1, 8'h07, 0, 0, 1, o(0, 1, 0, 0, 1, 2'b10, 0, 0, 8'h07, 0, 0)));
        // JZ taken / not taken
        tbl.push_back(v(1, 8'h09, 1, 0, 0, IR));
        tbl.push_back(v(1, 8'h09, 1, 0, 0, N));
        tbl.push_back(v(1, 8'h09, 1, 0, 0, LDPC0));
        tbl.push_back(v(1, 8'h09, 0, 1, 0, IR));
        tbl.push_back(v(1, 8'h09, 0, 1, 0, N));
        tbl.push_back(v(1, 8'h09, 0, 1, 0, INC));
        // JC taken / not taken (z must not matter)
        tbl.push_back(v(1, 8'h0A, 0, 1, 0, IR));
        tbl.push_back(v(1, 8'h0A, 0, 1, 0, N));
        tbl.push_back(v(1, 8'h0A, 0, 1, 0, LDPC0));
        tbl.push_back(v(1, 8'h0A, 1, 0, 0, IR));
        tbl.push_back(v(1, 8'h0A, 1, 0, 0, N));
        tbl.push_back(v(1, 8'h0A, 1, 0, 0, INC));
        // JMPM
        tbl.push_back(v(1, 8'h0B, 0, 0, 1, IR));
        tbl.push_back(v(1, 8'h0B, 0, 0, 1, N));
        tbl.push_back(v(1, 8'h0B, 0, 0, 1, RD));
        tbl.push_back(v(1, 8'h0B, 0, 0, 0, LDPC1));
        // STA with one wait
        tbl.push_back(v(1, 8'h03, 0, 0, 0, IR));
        tbl.push_back(v(1, 8'h03, 0, 0, 0, N));
        tbl.push_back(v(1, 8'h03, 0, 0, 0, WR));
        tbl.push_back(v(1, 8'h03, 0, 0, 1, WRINC));
        // JMP, NOP
        tbl.push_back(v(1, 8'h08, 0, 0, 0, IR));
        tbl.push_back(v(1, 8'h08, 0, 0, 0, N));
        tbl.push_back(v(1, 8'h08, 0, 0, 0, LDPC0));
        tbl.push_back(v(1, 8'h00, 0, 0, 0, IR));
        tbl.push_back(v(1, 8'h00, 0, 0, 0, N));
        tbl.push_back(v(1, 8'h00, 0, 0, 0, INC));
        // pause
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 8'h01, 0, 0, 1, N));
        // HLT is terminal
        tbl.push_back(v(1, 8'hFF, 0, 0, 0, IR));
        tbl.push_back(v(1, 8'hFF, 0, 0, 0, N));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 8'hFF, 0, 0, 1, HLT_E));

        do_reset("reset_initial");
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl[%0d]", i), tbl[i].run, tbl[i].op, tbl[i].z, tbl[i].c,
                 tbl[i].rdy, tbl[i].exp);

        // Illegal opcode: skipped as NOP, fault then stays set
        do_reset("reset_from_halt");
        step("ill_fetch", 1, 8'h3C, 0, 0, 0, IR);
        step("ill_decode", 1, 8'h3C, 0, 0, 0, N);
        step("ill_exec", 1, 8'h3C, 0, 0, 0, FLTINC);
        step("sticky_fetch", 1, 8'h00, 0, 0, 0, IRF);
        step("sticky_decode", 1, 8'h00, 0, 0, 0, FLT);
        step("sticky_exec", 1, 8'h00, 0, 0, 0, INCF);

        // STA timeout: 15 unanswered write cycles, then terminal FAULT
        do_reset("reset_from_fault");
        step("tmo_fetch", 1, 8'h03, 0, 0, 0, IR);
        step("tmo_decode", 1, 8'h03, 0, 0, 0, N);
        for (int i = 0; i < 15; i++) step($sformatf("tmo_wait%0d", i), 1, 8'h03, 0, 0, 0, WR);
        for (int i = 0; i < 3; i++) step($sformatf("tmo_fault%0d", i), 1, 8'h03, 0, 0, 1, FLT);

        // Asynchronous reset in the middle of a read
        do_reset("reset_clear_fault");
        step("t1_fetch", 1, 8'h02, 0, 0, 0, IR);
        step("t1_decode", 1, 8'h02, 0, 0, 0, N);
        step("t1_rd0", 1, 8'h02, 0, 0, 0, RD);
        drive(1, 8'h02, 0, 0, 0, RD);
        apply("t1_rd1");
        #1 rstn = 1'b0;
        #1 check("t1_async_reset", N);
        adv();
        rstn = 1'b1;
        // Counter restarts from zero: 14 waits then ready must not fault
        step("t1_refetch", 1, 8'h02, 0, 0, 0, IR);
        step("t1_redecode", 1, 8'h02, 0, 0, 0, N);
        for (int i = 0; i < 14; i++) step($sformatf("t1_wait%0d", i), 1, 8'h02, 0, 0, 0, RD);
        step("t1_ready", 1, 8'h02, 0, 0, 1, RD);
        step("t1_exec", 1, 8'h02, 0, 0, 0, LDA_E);
        step("t1_next_fetch", 1, 8'h00, 0, 0, 0, IR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
